// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit holding HI/LO; busy while a mult/div op is in flight.
// Define MDU_MADD_EN to build the madd/maddu/msub/msubu accumulate ops (7-10).
module mdu_seq #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       MDU_OP,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_DIV   = 4'd2;
   localparam logic [3:0] OP_MTHI  = 4'd3;
   localparam logic [3:0] OP_MTLO  = 4'd4;
   localparam logic [3:0] OP_MULTU = 4'd5;
   localparam logic [3:0] OP_DIVU  = 4'd6;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

   typedef enum logic {IDLE, RUN} state_t;

   state_t                 state, state_n;
   logic [CW-1:0]          cnt, cnt_n;
   logic [WIDTH-1:0]       phi, plo;
   logic                   launch, commit, op_valid, is_div;
   logic [2*WIDTH-1:0]     res;
   logic signed [2*WIDTH-1:0] sa_x, sb_x, prod_s;
   logic [2*WIDTH-1:0]     prod_u;

   // Unsigned divide returning {remainder, quotient}; caller screens out d == 0.
   function automatic logic [2*WIDTH-1:0] divu_f(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d);
      logic [WIDTH-1:0] ds;
      ds = (d == '0) ? WIDTH'(1) : d;
      return {n % ds, n / ds};
   endfunction

   // Signed divide truncating toward zero; most-negative / -1 saturates to {0, most-negative}.
   function automatic logic [2*WIDTH-1:0] divs_f(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d);
      logic signed [WIDTH-1:0] sn, sd, q, r;
      if (n == {1'b1, {(WIDTH-1){1'b0}}} && d == '1) begin
         return {{WIDTH{1'b0}}, n};
      end
      sn = n;
      sd = (d == '0) ? WIDTH'(1) : d;
      q  = sn / sd;
      r  = sn % sd;
      return {r, q};
   endfunction

   assign sa_x   = {{WIDTH{A[WIDTH-1]}}, A};
   assign sb_x   = {{WIDTH{B[WIDTH-1]}}, B};
   assign prod_s = sa_x * sb_x;
   assign prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

   // Operation decode and result; a zero divisor leaves the current HI/LO as the result.
   always_comb begin
      op_valid = 1'b0;
      is_div   = 1'b0;
      res      = {HI, LO};
      case (MDU_OP)
         OP_MULT:  begin op_valid = 1'b1; res = prod_s; end
         OP_MULTU: begin op_valid = 1'b1; res = prod_u; end
         OP_DIV: begin
            op_valid = 1'b1;
            is_div   = 1'b1;
            if (B != '0) res = divs_f(A, B);
         end
         OP_DIVU: begin
            op_valid = 1'b1;
            is_div   = 1'b1;
            if (B != '0) res = divu_f(A, B);
         end
`ifdef MDU_MADD_EN
         OP_MADD:  begin op_valid = 1'b1; res = {HI, LO} + prod_s; end
         OP_MADDU: begin op_valid = 1'b1; res = {HI, LO} + prod_u; end
         OP_MSUB:  begin op_valid = 1'b1; res = {HI, LO} - prod_s; end
         OP_MSUBU: begin op_valid = 1'b1; res = {HI, LO} - prod_u; end
`endif
         default: ;
      endcase
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      launch  = 1'b0;
      commit  = 1'b0;
      case (state)
         IDLE: begin
            if (start && op_valid) begin
               launch  = 1'b1;
               state_n = RUN;
               cnt_n   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end
         end
         RUN: begin
            cnt_n = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               commit  = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // Result is latched at launch and only becomes architectural on the final busy edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         phi <= '0;
         plo <= '0;
         HI  <= '0;
         LO  <= '0;
      end else begin
         if (launch) begin
            {phi, plo} <= res;
         end
         if (commit) begin
            HI <= phi;
            LO <= plo;
         end else if (state == IDLE) begin
            if (MDU_OP == OP_MTHI) HI <= A;
            if (MDU_OP == OP_MTLO) LO <= A;
         end
      end
   end

   assign busy = (state == RUN);

endmodule

// File: tb/tb_mdu_seq.sv
// Randomised bench for mdu_seq: a 32-bit default instance and a 16-bit single-cycle-mult instance.
module tb_mdu_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start0, start1, busy0, busy1;
   logic [3:0]  op0, op1;
   logic [31:0] a0, b0, hi0, lo0;
   logic [15:0] a1, b1, hi1, lo1;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [63:0] hl_m [2];

   always #5 clk = ~clk;

   mdu_seq u_mdu32 (
      .clk(clk), .reset(reset), .start(start0), .MDU_OP(op0),
      .A(a0), .B(b0), .busy(busy0), .HI(hi0), .LO(lo0)
   );

   mdu_seq #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) u_mdu16 (
      .clk(clk), .reset(reset), .start(start1), .MDU_OP(op1),
      .A(a1), .B(b1), .busy(busy1), .HI(hi1), .LO(lo1)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input int sel, input logic st, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
      if (sel == 0) begin
         start0 = st; op0 = op; a0 = a; b0 = b;
      end else begin
         start1 = st; op1 = op; a1 = a[15:0]; b1 = b[15:0];
      end
   endtask

   function automatic logic cur_busy(input int sel);
      return (sel == 0) ? busy0 : busy1;
   endfunction

   function automatic logic [63:0] cur_hl(input int sel);
      return (sel == 0) ? {hi0, lo0} : {32'h0, hi1, lo1};
   endfunction

   function automatic int lat_of(input int sel, input logic st, input logic [3:0] op);
      int ml, dl;
      ml = (sel == 0) ? 5 : 1;
      dl = (sel == 0) ? 10 : 3;
      if (!st) return 0;
      case (op)
         4'd1, 4'd5: return ml;
         4'd2, 4'd6: return dl;
`ifdef MDU_MADD_EN
         4'd7, 4'd8, 4'd9, 4'd10: return ml;
`endif
         default: return 0;
      endcase
   endfunction

   // Reference: {HI,LO} packed as a 2w-bit value in the low bits of 64, computed with wide integers.
   function automatic logic [63:0] ref_op(input int w, input logic [3:0] op,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [63:0] hl);
      logic [63:0] m, fm, ua, ub, up;
      longint      sa, sb, ps, q, rm;
      m  = (64'd1 << w) - 64'd1;
      fm = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
      ua = {32'h0, a} & m;
      ub = {32'h0, b} & m;
      sa = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
      sb = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
      ps = sa * sb;
      up = ua * ub;
      case (op)
         4'd1: return 64'(ps) & fm;
         4'd5: return up & fm;
         4'd2: begin
            if (ub == 0) return hl;
            q  = sa / sb;
            rm = sa % sb;
            return ((64'(rm) & m) << w) | (64'(q) & m);
         end
         4'd6: begin
            if (ub == 0) return hl;
            return (((ua % ub) & m) << w) | ((ua / ub) & m);
         end
         4'd3: return (ua << w) | (hl & m);
         4'd4: return (hl & (fm & ~m)) | ua;
         4'd7: return (hl + 64'(ps)) & fm;
         4'd8: return (hl + up) & fm;
         4'd9: return (hl - 64'(ps)) & fm;
         4'd10: return (hl - up) & fm;
         default: return hl;
      endcase
   endfunction

   // Issue one op; optionally throw stray starts/moves at the unit while it is busy.
   task automatic do_op(input int sel, input logic st, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic junk);
      int          n, lat, w;
      logic [63:0] old;
      w   = (sel == 0) ? 32 : 16;
      lat = lat_of(sel, st, op);
      old = hl_m[sel];
      @(negedge clk);
      drive(sel, st, op, a, b);
      @(negedge clk);
      drive(sel, 1'b0, 4'd0, 32'h0, 32'h0);
      if (lat > 0) chk("hold_during_busy", cur_hl(sel), old);
      n = 0;
      while (cur_busy(sel) && n < 40) begin
         n++;
         if (junk) drive(sel, 1'b1, 4'($urandom_range(1, 10)), $urandom, $urandom);
         @(negedge clk);
      end
      drive(sel, 1'b0, 4'd0, 32'h0, 32'h0);
      if (op == 4'd3 || op == 4'd4 || lat > 0) hl_m[sel] = ref_op(w, op, a, b, old);
      chk($sformatf("busy_cycles op%0d", op), 64'(n), 64'(lat));
      chk($sformatf("hilo op%0d", op), cur_hl(sel), hl_m[sel]);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int          sel;
      logic [3:0]  op;
      logic        st;
      logic [31:0] a, b;

      reset = 1'b1;
      drive(0, 1'b0, 4'd0, 32'h0, 32'h0);
      drive(1, 1'b0, 4'd0, 32'h0, 32'h0);
      hl_m[0] = '0;
      hl_m[1] = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("reset_busy32", 64'(busy0), 64'd0);
      chk("reset_hilo32", cur_hl(0), 64'd0);
      chk("reset_busy16", 64'(busy1), 64'd0);
      chk("reset_hilo16", cur_hl(1), 64'd0);

      do_op(0, 1'b1, 4'd1, 32'hFFFF_FFFD, 32'd5, 1'b0);
      chk("mult_hi", 64'(hi0), 64'hFFFF_FFFF);
      chk("mult_lo", 64'(lo0), 64'hFFFF_FFF1);

      do_op(0, 1'b1, 4'd6, 32'd7, 32'd2, 1'b0);
      chk("divu_lo", 64'(lo0), 64'd3);
      chk("divu_hi", 64'(hi0), 64'd1);

      do_op(0, 1'b1, 4'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
      chk("div_lo", 64'(lo0), 64'hFFFF_FFFD);
      chk("div_hi", 64'(hi0), 64'hFFFF_FFFF);

      do_op(0, 1'b0, 4'd3, 32'h1234_5678, 32'h0, 1'b0);
      do_op(0, 1'b1, 4'd2, 32'd5, 32'd0, 1'b1);
      chk("divz_hi", 64'(hi0), 64'h1234_5678);
      chk("divz_lo", 64'(lo0), 64'hFFFF_FFFD);

      // Reset in the third busy cycle must drop everything with no late commit.
      @(negedge clk);
      drive(0, 1'b1, 4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      @(negedge clk);
      drive(0, 1'b0, 4'd0, 32'h0, 32'h0);
      repeat (2) @(negedge clk);
      chk("busy_before_reset", 64'(busy0), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      hl_m[0] = '0;
      hl_m[1] = '0;
      chk("midrst_busy", 64'(busy0), 64'd0);
      chk("midrst_hilo", cur_hl(0), 64'd0);
      repeat (12) @(negedge clk);
      chk("midrst_no_late_commit", cur_hl(0), 64'd0);
      chk("midrst_idle", 64'(busy0), 64'd0);

`ifdef MDU_MADD_EN
      do_op(0, 1'b0, 4'd4, 32'd10, 32'h0, 1'b0);
      do_op(0, 1'b0, 4'd3, 32'd0, 32'h0, 1'b0);
      do_op(0, 1'b1, 4'd7, 32'd3, 32'd4, 1'b0);
      chk("madd_lo", 64'(lo0), 64'd22);
      chk("madd_hi", 64'(hi0), 64'd0);
      do_op(0, 1'b1, 4'd10, 32'd1, 32'd23, 1'b0);
      chk("msubu_hi", 64'(hi0), 64'hFFFF_FFFF);
      chk("msubu_lo", 64'(lo0), 64'hFFFF_FFFF);
`endif

      do_op(1, 1'b1, 4'd1, 32'h8000, 32'h8000, 1'b1);
      chk("mult16_hi", 64'(hi1), 64'h4000);
      chk("mult16_lo", 64'(lo1), 64'h0000);

      for (int i = 0; i < 150; i++) begin
         sel = $urandom_range(0, 1);
         op  = 4'($urandom_range(0, 15));
         st  = ($urandom_range(0, 7) != 0);
         a   = $urandom;
         b   = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'h0;
            1: begin a = (sel == 0) ? 32'h8000_0000 : 32'h0000_8000; b = 32'hFFFF_FFFF; end
            2: begin a = $urandom_range(0, 20); b = $urandom_range(0, 7); end
            default: ;
         endcase
         do_op(sel, st, op, a, b, 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
